uart_tx_frame: RTL and testbench

Parametrised UART serializer with a runtime-configurable frame format: data width set at build time; baud divisor, parity mode and stop-bit count set per frame. It accepts bytes over a valid/ready handshake and drives one serial line, LSB first. It sits between a byte source (register block or FIFO) and the pad. Unlike a fixed-format transmitter, it restarts its baud timing at every frame start, so start-bit width is exact.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_frame_if.sv | 24 ++
 rtl/uart_baud_cnt.sv | 41 ++++
 rtl/uart_tx_frame.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive path.
// Parity encodings, FSM states and legal data-width limits.
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between a byte source and the UART serializer.
// The source is master; the serializer is slave.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  import uart_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Baud-period down-counter: load sets a new divisor and restarts,
// expiry marks the last cycle of each bit period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_expire,
  output logic             o_pre
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_cnt <= i_div - ONE;
    end else if (i_restart || r_cnt == '0) begin
      r_cnt <= r_div - ONE;
    end else begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_expire = (r_cnt == '0);
  // high when the next cycle will expire, assuming no load
  assign o_pre = (r_cnt == ONE) ||
                 (r_cnt == '0 && r_div == ONE);

endmodule

// File: rtl/uart_tx_frame.sv
// UART serializer with per-frame divisor, parity and stop count.
// Baud timing restarts on every accept so the start bit is exact.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_frame_if.slave   s_in,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       parity_mode,
  input  logic             two_stop,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  if (DATA_BITS < DATA_BITS_MIN ||
      DATA_BITS > DATA_BITS_MAX) begin : g_bad_width
    $error("DATA_BITS must be in 5..9");
  end

  localparam int BW =
    $clog2(DATA_BITS > 2 ? DATA_BITS : 2);
  localparam logic [BW-1:0] LAST_D = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  state_e               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bit;
  logic                 r_par;
  logic [1:0]           r_pmode;
  logic                 r_two;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_ready;
  logic                 r_done;

  logic             w_acc;
  logic [DIV_W-1:0] w_div;
  logic             w_exp;
  logic             w_pre;
  logic             w_par_en;
  logic             w_par_bit;
  logic [BW-1:0]    w_last_stop;
  logic             w_stop_end;
  logic             w_fin_now;
  logic             w_fin_enter;
  logic             w_done_nxt;

  assign w_acc = s_in.in_valid && r_ready;
  assign w_div = (baud_div == '0) ? DIV_W'(1) : baud_div;

  assign w_par_en  = (r_pmode == PAR_EVEN) ||
                     (r_pmode == PAR_ODD);
  assign w_par_bit = r_par ^ r_shift[0] ^
                     (r_pmode == PAR_ODD);

  assign w_last_stop = r_two ? B_ONE : '0;
  assign w_stop_end  = (r_state == STOP) && w_exp &&
                       (r_bit == w_last_stop);

  uart_baud_cnt #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_acc),
    .i_restart (w_stop_end),
    .i_div     (w_div),
    .o_expire  (w_exp),
    .o_pre     (w_pre)
  );

  // predict the last cycle of the final stop bit one edge early
  assign w_fin_now   = (r_state == STOP) &&
                       (r_bit == w_last_stop);
  assign w_fin_enter =
    ((r_state == DATA && r_bit == LAST_D && !w_par_en) ||
     r_state == PARITY) ? !r_two :
    (r_state == STOP && r_bit == '0 && r_two);
  assign w_done_nxt  = w_pre &&
                       (w_exp ? w_fin_enter : w_fin_now);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_pmode <= PAR_NONE;
      r_two   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_state <= START;
            r_shift <= s_in.in_data;
            r_pmode <= parity_mode;
            r_two   <= two_stop;
            r_par   <= 1'b0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        START: begin
          if (w_exp) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_exp) begin
            if (r_bit == LAST_D) begin
              r_bit <= '0;
              if (w_par_en) begin
                r_state <= PARITY;
                r_tx    <= w_par_bit;
              end else begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + B_ONE;
              r_shift <= r_shift >> 1;
              r_par   <= r_par ^ r_shift[0];
              r_tx    <= r_shift[1];
            end
          end
        end
        PARITY: begin
          if (w_exp) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
            r_bit   <= '0;
          end
        end
        STOP: begin
          if (w_exp) begin
            if (r_bit == w_last_stop) begin
              r_state <= IDLE;
              r_bit   <= '0;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_bit <= r_bit + B_ONE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign s_in.in_ready = r_ready;
  assign tx            = r_tx;
  assign busy          = r_busy;
  assign frame_done    = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: accepted frames go to a
// scoreboard and a line monitor checks every serial cycle.
module tb_uart_tx_frame;

  logic        clk;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        tx;
  logic        busy;
  logic        frame_done;

  uart_tx_frame_if #(.DATA_BITS(8)) u_if ();

  uart_tx_frame #(
    .DATA_BITS (8),
    .DIV_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_in        (u_if),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [7:0] d;
    int         div;
    logic [1:0] pm;
    logic       ts;
  } fr_t;

  fr_t q[$];
  int  n_err = 0;
  int  n_chk = 0;
  int  n_acc = 0;
  int  cyc = 0;
  int  last_done = 0;
  int  last_gap = 0;
  int  n_start = 0;
  logic mon_busy = 1'b0;
  logic pbusy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // scoreboard push on every handshake
  always @(posedge clk) begin
    if (!rst && u_if.in_valid && u_if.in_ready) begin
      fr_t f;
      f.d   = u_if.in_data;
      f.div = int'(baud_div);
      f.pm  = parity_mode;
      f.ts  = two_stop;
      q.push_back(f);
      n_acc++;
    end
  end

  task automatic run_frame();
    fr_t  f;
    logic b[$];
    int   dv;
    int   len;
    mon_busy = 1'b1;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      mon_busy = 1'b0;
      return;
    end
    f = q.pop_front();
    last_gap = cyc - last_done;
    n_start++;
    dv = (f.div == 0) ? 1 : f.div;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(f.d[i]);
    if (f.pm == 2'd1) b.push_back(^f.d);
    if (f.pm == 2'd2) b.push_back(~^f.d);
    b.push_back(1'b1);
    if (f.ts) b.push_back(1'b1);
    len = dv * b.size();
    for (int k = 1; k <= len; k++) begin
      if (k > 1) @(negedge clk);
      if (rst) begin
        mon_busy = 1'b0;
        return;
      end
      chk("tx", {31'd0, tx}, {31'd0, b[(k-1)/dv]});
      chk("frame_done", {31'd0, frame_done},
          {31'd0, k == len});
      chk("busy", {31'd0, busy}, 32'd1);
      if (k == len) last_done = cyc;
    end
    @(negedge clk);
    if (!rst) begin
      chk("end_busy", {31'd0, busy}, 32'd0);
      chk("end_ready", {31'd0, u_if.in_ready}, 32'd1);
      chk("end_tx", {31'd0, tx}, 32'd1);
    end
    mon_busy = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && busy && !pbusy) run_frame();
      pbusy = busy;
    end
  end

  task automatic send(input logic [7:0]  d,
                      input logic [15:0] dv,
                      input logic [1:0]  pm,
                      input logic        ts);
    int n0;
    n0 = n_acc;
    @(negedge clk);
    u_if.in_data  = d;
    baud_div      = dv;
    parity_mode   = pm;
    two_stop      = ts;
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_acc != n0) break;
    end
    u_if.in_valid = 1'b0;
    chk("accept", {31'd0, n_acc != n0}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!mon_busy && !busy && q.size() == 0) return;
    end
    chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int base;
    rst           = 1'b1;
    u_if.in_data  = '0;
    u_if.in_valid = 1'b0;
    baud_div      = 16'd4;
    parity_mode   = 2'd0;
    two_stop      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, u_if.in_ready}, 32'd1);

    send(8'hA5, 16'd4, 2'd0, 1'b0);
    wait_idle();
    send(8'h07, 16'd2, 2'd1, 1'b0);
    wait_idle();
    send(8'h07, 16'd2, 2'd2, 1'b0);
    wait_idle();

    // held in_valid: two back-to-back frames
    base = n_acc;
    @(negedge clk);
    u_if.in_data  = 8'hFF;
    baud_div      = 16'd3;
    parity_mode   = 2'd0;
    two_stop      = 1'b1;
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_acc - base >= 2) break;
    end
    u_if.in_valid = 1'b0;
    wait_idle();
    chk("held_accepts", n_acc - base, 32'd2);
    chk("held_gap", last_gap, 32'd2);

    send(8'h01, 16'd0, 2'd0, 1'b0);
    wait_idle();

    // inputs change mid-frame
    send(8'h96, 16'd5, 2'd1, 1'b0);
    repeat (10) @(negedge clk);
    u_if.in_data = 8'h11;
    baud_div     = 16'd2;
    parity_mode  = 2'd2;
    two_stop     = 1'b1;
    wait_idle();
    send(8'h11, 16'd2, 2'd2, 1'b1);
    wait_idle();

    // reset at cycle 15 of a div=4 frame
    send(8'h5A, 16'd4, 2'd0, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_done", {31'd0, frame_done}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, u_if.in_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    send(8'h3C, 16'd4, 2'd0, 1'b0);
    wait_idle();

    chk("total_accepts", n_acc, 32'd10);
    chk("total_starts", n_start, 32'd10);
    chk("sb_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
